// File: rtl/vram_pkg.sv
// Shared types and widths for the VRAM scan arbiter and its prefetch FIFO.
package vram_pkg;

    localparam int VRAM_ADDR_W = 10;
    localparam int VRAM_DATA_W = 32;

    // CPU-side transaction state: CPU_RD is the cycle the VRAM returns CPU read data.
    typedef enum logic {
        IDLE   = 1'b0,
        CPU_RD = 1'b1
    } fsm_state_t;

    // Owner of the single VRAM port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_SCAN = 2'd2
    } grant_t;

endpackage

// File: rtl/vram_scan_fifo.sv
// Small synchronous FIFO holding prefetched scan words plus their start-of-frame tag.
// A flush empties it in one cycle and takes priority over a same-cycle push or pop.
module vram_scan_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_ok   = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = store[rd_ptr];

    // Data storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_scan_arbiter.sv
// Shares the single-port VRAM between the Nios Avalon-MM slave and the video scanout.
// The scan side walks VRAM linearly into a prefetch FIFO; the CPU is guaranteed service
// after at most CPU_MAX_WAIT lost arbitration cycles.
//
// Stream handshake: a word transfers on every rising clock edge where vid_valid and
// vid_ready are both high; vid_valid depends only on registered FIFO state and never
// on vid_ready, and vid_data/vid_sof stay stable while vid_valid is high and vid_ready low.
module vram_scan_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int SCAN_WORDS   = 1024,
    parameter int FIFO_DEPTH   = 4,
    parameter int LOW_WATER    = 2,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic [DATA_W/8-1:0] cpu_byteenable,
    input  logic                cpu_chipselect,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [DATA_W-1:0]   cpu_writedata,
    output logic [DATA_W-1:0]   cpu_readdata,
    output logic                cpu_waitrequest,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_clken,
    input  logic                scan_enable,
    input  logic                frame_start,
    output logic [DATA_W-1:0]   vid_data,
    output logic                vid_sof,
    output logic                vid_valid,
    input  logic                vid_ready
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int LVL_W  = CNT_W + 1;
    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1) + 1;

    fsm_state_t        state;
    grant_t            grant;
    logic [ADDR_W-1:0] scan_addr;
    logic              inflight;
    logic              inflight_sof;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_rdata;
    logic [LVL_W-1:0]  level;
    logic              flush;
    logic              cpu_req;
    logic              scan_req;
    logic              fifo_push;
    logic              fifo_pop;

    // Outstanding scan reads count toward the level so the FIFO can never overflow.
    assign level   = LVL_W'(fifo_count) + LVL_W'(inflight);
    assign flush   = frame_start | ~scan_enable;
    assign cpu_req = cpu_chipselect & (cpu_read | cpu_write);
    // No scan read is issued in a flush cycle: the address is being rewound to 0.
    assign scan_req = scan_enable & ~frame_start & (level < LVL_W'(FIFO_DEPTH));

    // Per-cycle owner of the VRAM port; earlier branches take precedence.
    always_comb begin
        grant = GNT_NONE;
        if (state == CPU_RD) begin
            grant = scan_req ? GNT_SCAN : GNT_NONE;
        end else if (cpu_req && (wait_cnt == WAIT_W'(CPU_MAX_WAIT))) begin
            grant = GNT_CPU;
        end else if (scan_req && (level < LVL_W'(LOW_WATER))) begin
            grant = GNT_SCAN;
        end else if (cpu_req) begin
            grant = GNT_CPU;
        end else if (scan_req) begin
            grant = GNT_SCAN;
        end
    end

    // CPU transaction FSM: a granted read spends one extra cycle waiting for VRAM data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (grant == GNT_CPU && !cpu_write) state <= CPU_RD;
                CPU_RD:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Starvation counter: counts cycles a pending CPU request loses the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (grant == GNT_CPU || !cpu_req) begin
            wait_cnt <= '0;
        end else if (state == IDLE && wait_cnt != WAIT_W'(CPU_MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Scan address walker and the one-deep in-flight read tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_addr    <= '0;
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
        end else if (flush) begin
            scan_addr    <= '0;
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
        end else begin
            inflight <= (grant == GNT_SCAN);
            if (grant == GNT_SCAN) begin
                inflight_sof <= (scan_addr == '0);
                scan_addr    <= (scan_addr == ADDR_W'(SCAN_WORDS - 1)) ? '0 : scan_addr + 1'b1;
            end
        end
    end

    // Returning scan data is dropped if a flush lands in the same cycle.
    assign fifo_push = inflight & ~flush;
    assign fifo_pop  = vid_valid & vid_ready;

    vram_scan_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (fifo_push),
        .push_data ({inflight_sof, mem_readdata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign vid_valid = ~fifo_empty;
    assign vid_data  = fifo_rdata[DATA_W-1:0];
    assign vid_sof   = fifo_rdata[DATA_W];

    // VRAM port drive; reset forces the port quiet even before the clock runs.
    assign mem_clken      = 1'b1;
    assign mem_chipselect = ~reset & (grant != GNT_NONE);
    assign mem_write      = ~reset & (grant == GNT_CPU) & cpu_write;
    assign mem_address    = (grant == GNT_CPU) ? cpu_address : scan_addr;
    assign mem_byteenable = (grant == GNT_CPU) ? cpu_byteenable : '1;
    assign mem_writedata  = cpu_writedata;

    // A CPU access completes as a granted write or in the read-data cycle.
    assign cpu_waitrequest = reset |
                             (cpu_req & ~(((grant == GNT_CPU) & cpu_write) | (state == CPU_RD)));
    assign cpu_readdata    = (state == CPU_RD) ? mem_readdata : '0;

endmodule

// File: doc/vram_scan_arbiter.md
Name: vram_scan_arbiter

Overview:
Shares the single-port 1024x32 on-chip VRAM between the Nios CPU (Avalon-MM slave side) and a video scanout stream. Walks VRAM linearly, prefetches words into a small internal FIFO, and presents them as a valid/ready pixel-word stream to the display pipeline. Sits between the Nios interconnect and the VRAM instance, and drives every VRAM port.

Parameters:
ADDR_W, 10, VRAM word-address width
DATA_W, 32, VRAM word width; byteenable width is DATA_W/8
SCAN_WORDS, 1024, words per frame; scan address wraps 0..SCAN_WORDS-1
FIFO_DEPTH, 4, scan prefetch FIFO depth; power of 2, at least 2
LOW_WATER, 2, scan gets priority while FIFO level plus in-flight reads is below this
CPU_MAX_WAIT, 4, maximum cycles a pending CPU access can lose arbitration

Ports:
clk  in  1  system clock, sole clock domain
reset  in  1  asynchronous, active-high reset
cpu_address  in  ADDR_W  CPU word address
cpu_byteenable  in  DATA_W/8  CPU byte lanes
cpu_chipselect  in  1  CPU access select
cpu_read  in  1  CPU read strobe
cpu_write  in  1  CPU write strobe
cpu_writedata  in  DATA_W  CPU write data
cpu_readdata  out  DATA_W  CPU read data; valid when read is high and waitrequest is low
cpu_waitrequest  out  1  Avalon stall
mem_address  out  ADDR_W  to VRAM address
mem_byteenable  out  DATA_W/8  to VRAM byteenable
mem_chipselect  out  1  to VRAM chipselect
mem_write  out  1  to VRAM write
mem_writedata  out  DATA_W  to VRAM writedata
mem_readdata  in  DATA_W  from VRAM readdata; 1-cycle read latency
mem_clken  out  1  VRAM clock enable; constant 1
scan_enable  in  1  scanout run; low stops scanout and flushes it
frame_start  in  1  single-cycle pulse; restart the scan at address 0
vid_data  out  DATA_W  scan word
vid_sof  out  1  high with the word read from address 0
vid_valid  out  1  FIFO not empty
vid_ready  in  1  consumer accept

Behaviour:
- Reset, asynchronous: FIFO empty, scan address 0, wait counter 0, FSM IDLE, no read in flight. Outputs during reset: vid_valid=0, cpu_waitrequest=1, mem_chipselect=0, mem_write=0, cpu_readdata=0.
- VRAM port: exactly one access per cycle. A read issued in cycle N returns mem_readdata in cycle N+1.
- CPU request = cpu_chipselect & (cpu_read | cpu_write).
- Scan request = scan_enable & (fifo_count + inflight < FIFO_DEPTH).
- Arbitration per cycle, first matching rule wins:
  - FSM in CPU_RD: no new CPU grant.
  - CPU wait counter equals CPU_MAX_WAIT: grant CPU.
  - Scan request and level (fifo_count + inflight) < LOW_WATER: grant scan.
  - CPU request: grant CPU.
  - Scan request: grant scan.
- Wait counter: increments each cycle the CPU request loses; clears when the CPU is granted.
- CPU write, granted in cycle N: mem_write=1 in cycle N, cpu_waitrequest=0 in cycle N.
- CPU read, granted in cycle N: FSM goes IDLE→CPU_RD, cpu_waitrequest=1 in N. In N+1, cpu_readdata=mem_readdata, cpu_waitrequest=0, FSM returns to IDLE. The port is free for a scan read in N+1.
- cpu_waitrequest=1 whenever a CPU request is pending and not completing that cycle; 0 when there is no request.
- Scan read: pushes mem_readdata into the FIFO in N+1, tagged sof = (address==0). Address increments and wraps SCAN_WORDS-1→0.
- FIFO: pop on vid_valid & vid_ready. Simultaneous push and pop leaves the level unchanged. Never overflows, because inflight is counted in the level.
- frame_start or scan_enable low: FIFO flushed, scan address set to 0, any in-flight scan data discarded (not pushed). A CPU transaction in flight completes normally. If frame_start and a push land in the same cycle, the flush wins.
- CPU reads never disturb the scan address. CPU writes are visible to any scan read issued in a later cycle.

Decomposition:
- Shared package vram_pkg:
  - VRAM_ADDR_W=10 and VRAM_DATA_W=32
  - FSM enum {IDLE, CPU_RD}
  - grant enum {GNT_NONE, GNT_CPU, GNT_SCAN}
- Sub-module vram_scan_fifo:
  - synchronous FIFO of DATA_W+1 bits (data plus sof) with count output
  - flush input

Test Plan:
- After reset, scan_enable=1, vid_ready=1, VRAM preloaded so that word[i]=i → vid_data streams 0,1,2,…,1023,0, with vid_sof high on words 0 and 1024.
- CPU writes 0xDEADBEEF to address 5 with byteenable 0xF, no scan active → waitrequest low the same cycle. A CPU read of address 5 then has waitrequest high 1 cycle and readdata=0xDEADBEEF on the second cycle.
- Byte write: byteenable 0x2 with writedata 0x0000AA00 to address 7 (previously 0x11223344) → read returns 0x1122AA44.
- vid_ready=0 so the FIFO fills to 4, with the CPU hammering reads → every CPU read completes within 2 cycles and the scan issues no reads.
- vid_ready=1 with the FIFO below LOW_WATER and the CPU requesting continuously → the CPU is granted within CPU_MAX_WAIT+1=5 cycles and vid_valid never drops once the stream has started.
- frame_start pulsed mid-frame at address 300 with a scan read in flight → the FIFO is empty the next cycle, and the next vid_data is word 0 with vid_sof=1. Async reset asserted mid CPU read → waitrequest=1 and vid_valid=0 immediately.
